pio_edge_capture_db: RTL and testbench

//  Parametrised Avalon-MM input PIO with per-bit edge capture and interrupt.

---
 rtl/pio_edge_capture_db.sv | 90 +++++++++
 tb/tb_pio_edge_capture_db.sv | 124 ++++++++++++
 2 files changed

// File: rtl/pio_edge_capture_db.sv
// pio_edge_capture_db: Avalon-MM input PIO with per-bit sync, optional debounce,
// rise/fall edge capture and a level interrupt.
//   clk, reset_n          clock, asynchronous active-low reset
//   address[2:0]          register word address (0 data, 1 rise_en, 2 irq_mask,
//                         3 edge_capture W1C, 4 fall_en, 5..7 read 0)
//   chipselect, write_n   write strobe is chipselect & ~write_n
//   writedata[31:0]       write data
//   in_port[WIDTH-1:0]    asynchronous external inputs
//   irq                   |(edge_capture & irq_mask)
//   readdata[31:0]        registered read data, 1 clk latency
// Build option: define PIO_DEBOUNCE_EN to insert per-bit debounce counters.
module pio_edge_capture_db #(
   parameter int               WIDTH         = 4,
   parameter int               DB_CYCLES     = 50000,
   parameter logic [WIDTH-1:0] IN_RESET      = '1,
   parameter logic [WIDTH-1:0] RISE_EN_RESET = '0,
   parameter logic [WIDTH-1:0] FALL_EN_RESET = '1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq,
   output logic [31:0]      readdata
);
   logic [WIDTH-1:0] r_sync1, r_sync2, r_prev, r_rise_en, r_fall_en, r_mask, r_cap;
   logic [WIDTH-1:0] w_stable, w_wd, w_rd, w_event;
   logic             w_wr;
   logic             w_unused;
   assign w_wr     = chipselect & ~write_n;
   assign w_wd     = writedata[WIDTH-1:0];
   assign w_unused = ^{1'b0, writedata};
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         r_sync1 <= IN_RESET;
         r_sync2 <= IN_RESET;
      end else begin
         r_sync1 <= in_port;
         r_sync2 <= r_sync1;
      end
`ifdef PIO_DEBOUNCE_EN
   localparam int CW = $clog2(DB_CYCLES);
   logic [WIDTH-1:0] r_stable;
   logic [CW-1:0]    r_cnt [WIDTH];
   // stable follows sync2 only after DB_CYCLES consecutive differing edges
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         r_stable <= IN_RESET;
         for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++)
            if (r_sync2[i] == r_stable[i]) r_cnt[i] <= '0;
            else if (r_cnt[i] == CW'(DB_CYCLES - 1)) begin
               r_stable[i] <= r_sync2[i];
               r_cnt[i]    <= '0;
            end else r_cnt[i] <= r_cnt[i] + 1'b1;
      end
   assign w_stable = r_stable;
`else
   // without debounce the second synchroniser flop is the stable value
   assign w_stable = r_sync2;
`endif
   assign w_event = (w_stable & ~r_prev & r_rise_en) | (~w_stable & r_prev & r_fall_en);
   assign irq     = |(r_cap & r_mask);
   assign w_rd    = address == 3'd0 ? w_stable  :
                    address == 3'd1 ? r_rise_en :
                    address == 3'd2 ? r_mask    :
                    address == 3'd3 ? r_cap     :
                    address == 3'd4 ? r_fall_en : '0;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         r_prev    <= IN_RESET;
         r_rise_en <= RISE_EN_RESET;
         r_fall_en <= FALL_EN_RESET;
         r_mask    <= '0;
         r_cap     <= '0;
         readdata  <= '0;
      end else begin
         r_prev    <= w_stable;
         r_rise_en <= (w_wr && address == 3'd1) ? w_wd : r_rise_en;
         r_mask    <= (w_wr && address == 3'd2) ? w_wd : r_mask;
         r_fall_en <= (w_wr && address == 3'd4) ? w_wd : r_fall_en;
         // a new event on the clearing edge wins over the W1C
         r_cap     <= (r_cap & ~((w_wr && address == 3'd3) ? w_wd : '0)) | w_event;
         readdata  <= 32'(w_rd);
      end
endmodule

// File: tb/tb_pio_edge_capture_db.sv
// tb_pio_edge_capture_db: directed self-checking bench for pio_edge_capture_db
// (WIDTH=4, DB_CYCLES=4); expectations follow the PIO_DEBOUNCE_EN build setting.
module tb_pio_edge_capture_db;
`ifdef PIO_DEBOUNCE_EN
   localparam bit DB = 1'b1;
`else
   localparam bit DB = 1'b0;
`endif
   // clk edges from an in_port change (driven just after an edge) to edge_capture set
   localparam int L = DB ? 7 : 3;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [3:0]  in_port = 4'hF;
   logic        irq;
   logic [31:0] readdata;
   int          n_cmp = 0;
   int          n_err = 0;
   pio_edge_capture_db #(.WIDTH(4), .DB_CYCLES(4)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port), .irq(irq),
      .readdata(readdata)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      step(1);
      chipselect = 1'b0; write_n = 1'b1;
   endtask
   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      address = a;
      step(1);
      d = readdata;
   endtask
   logic [31:0] v;
   initial begin
      step(3);
      chk("reset_readdata", readdata, 32'h0);
      chk("reset_irq", {31'b0, irq}, 32'h0);
      reset_n = 1'b1;
      rd(0, v); chk("rst_data", v, 32'h0000000F);
      rd(1, v); chk("rst_rise_en", v, 32'h0);
      rd(2, v); chk("rst_mask", v, 32'h0);
      rd(3, v); chk("rst_cap", v, 32'h0);
      rd(4, v); chk("rst_fall_en", v, 32'hF);
      rd(5, v); chk("rst_addr5", v, 32'h0);
      chk("rst_irq", {31'b0, irq}, 32'h0);
      wr(0, 32'h0); wr(7, 32'hF);
      rd(0, v); chk("data_ro", v, 32'hF);
      // falling edge on bit1
      wr(2, 32'hFFFF_FFF2);
      rd(2, v); chk("mask_width", v, 32'h2);
      in_port = 4'hD;
      step(L - 1); chk("fall_irq_early", {31'b0, irq}, 32'h0);
      step(1);     chk("fall_irq", {31'b0, irq}, 32'h1);
      rd(3, v); chk("fall_cap", v, 32'h2);
      rd(0, v); chk("fall_data", v, 32'hD);
      wr(3, 32'h2); chk("w1c_irq", {31'b0, irq}, 32'h0);
      rd(3, v); chk("w1c_cap", v, 32'h0);
      in_port = 4'hF;
      step(L + 2);
      rd(3, v); chk("rise_disabled_cap", v, 32'h0);
      rd(0, v); chk("rise_data", v, 32'hF);
      // 3-clk glitch on bit0
      in_port = 4'hE; step(3); in_port = 4'hF; step(L + 3);
      rd(0, v); chk("glitch_data", v, 32'hF);
      rd(3, v); chk("glitch_cap", v, DB ? 32'h0 : 32'h1);
      chk("glitch_irq", {31'b0, irq}, 32'h0);
      wr(3, 32'hF);
      // edge selection: rise only on bit0
      wr(1, 32'h1); wr(4, 32'h0); wr(2, 32'h1);
      in_port = 4'hE; step(L + 2);
      rd(3, v); chk("sel_fall_cap", v, 32'h0);
      rd(0, v); chk("sel_fall_data", v, 32'hE);
      in_port = 4'hF;
      step(L - 1); chk("sel_rise_irq_early", {31'b0, irq}, 32'h0);
      step(1);     chk("sel_rise_irq", {31'b0, irq}, 32'h1);
      rd(3, v); chk("sel_rise_cap", v, 32'h1);
      wr(1, 32'h0); rd(3, v); chk("en_clear_keeps_cap", v, 32'h1);
      wr(3, 32'h1);
      // race: W1C of bit1 on the edge a new bit1 rise is captured
      wr(1, 32'h2); wr(4, 32'hF); wr(2, 32'h2);
      in_port = 4'hD; step(L); chk("race_pre_irq", {31'b0, irq}, 32'h1);
      in_port = 4'hF; step(L - 1); chk("race_hold_irq", {31'b0, irq}, 32'h1);
      wr(3, 32'h2); chk("race_irq", {31'b0, irq}, 32'h1);
      rd(3, v); chk("race_cap", v, 32'h2);
      wr(3, 32'hF); chk("race_clear_irq", {31'b0, irq}, 32'h0);
      // 1-clk pulse on bit2
      wr(2, 32'h4);
      in_port = 4'hB; step(1); in_port = 4'hF;
      step(1); chk("pulse_irq_early", {31'b0, irq}, 32'h0);
      step(1); chk("pulse_irq", {31'b0, irq}, DB ? 32'h0 : 32'h1);
      rd(3, v); chk("pulse_cap", v, DB ? 32'h0 : 32'h4);
      wr(3, 32'hF);
      // reset in the middle of a debounce
      in_port = 4'hE; step(4);
      reset_n = 1'b0; #1;
      chk("midrst_readdata", readdata, 32'h0);
      chk("midrst_irq", {31'b0, irq}, 32'h0);
      in_port = 4'hF; step(2); reset_n = 1'b1;
      step(L + 2);
      rd(0, v); chk("midrst_data", v, 32'hF);
      rd(3, v); chk("midrst_cap", v, 32'h0);
      rd(2, v); chk("midrst_mask", v, 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
